// File: rtl/parallel_comparator_8bit_core.sv
// 8-bit magnitude comparator using a log-depth greater/less merge tree, with optional output register.
// Define PARALLEL_COMPARATOR_8BIT_SIGNED_EN for a two's-complement compare; the default build is unsigned.
module parallel_comparator_8bit_core #(
    parameter int OUT_REG = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       in_valid,
    output logic       g,
    output logic       l,
    output logic       eq,
    output logic       out_valid
);

    logic [7:0] w_gBit;
    logic [7:0] w_lBit;
    logic [3:0] w_gPair;
    logic [3:0] w_lPair;
    logic [1:0] w_gNib;
    logic [1:0] w_lNib;
    logic       w_gByte;
    logic       w_lByte;
    logic       w_eqByte;

    // A signed compare only changes the sign bit: a set sign bit marks the smaller operand.
    always_comb begin
        w_gBit = A & ~B;
        w_lBit = ~A & B;
`ifdef PARALLEL_COMPARATOR_8BIT_SIGNED_EN
        w_gBit[7] = ~A[7] & B[7];
        w_lBit[7] = A[7] & ~B[7];
`else
        w_gBit[7] = A[7] & ~B[7];
        w_lBit[7] = ~A[7] & B[7];
`endif
    end

    for (genvar j = 0; j < 4; j++) begin : g_pairMerge
        assign w_gPair[j] = w_gBit[2*j+1] | (~w_lBit[2*j+1] & w_gBit[2*j]);
        assign w_lPair[j] = w_lBit[2*j+1] | (~w_gBit[2*j+1] & w_lBit[2*j]);
    end

    for (genvar k = 0; k < 2; k++) begin : g_nibMerge
        assign w_gNib[k] = w_gPair[2*k+1] | (~w_lPair[2*k+1] & w_gPair[2*k]);
        assign w_lNib[k] = w_lPair[2*k+1] | (~w_gPair[2*k+1] & w_lPair[2*k]);
    end

    assign w_gByte  = w_gNib[1] | (~w_lNib[1] & w_gNib[0]);
    assign w_lByte  = w_lNib[1] | (~w_gNib[1] & w_lNib[0]);
    assign w_eqByte = ~w_gByte & ~w_lByte;

    if (OUT_REG != 0) begin : g_regOut
        logic r_g;
        logic r_l;
        logic r_eq;
        logic r_valid;

        // Results hold while idle; only the valid flag tracks in_valid every cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_g     <= 1'b0;
                r_l     <= 1'b0;
                r_eq    <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= in_valid;
                if (in_valid) begin
                    r_g  <= w_gByte;
                    r_l  <= w_lByte;
                    r_eq <= w_eqByte;
                end
            end
        end

        assign g         = r_g;
        assign l         = r_l;
        assign eq        = r_eq;
        assign out_valid = r_valid;
    end else begin : g_combOut
        logic w_unusedClkRst;
        assign w_unusedClkRst = clk | rst_n;

        assign g         = w_gByte;
        assign l         = w_lByte;
        assign eq        = w_eqByte;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_parallel_comparator_8bit_core.sv
// Self-checking bench for parallel_comparator_8bit_core: registered and combinational instances
// checked against an integer-arithmetic reference model (signed when PARALLEL_COMPARATOR_8BIT_SIGNED_EN).
module tb_parallel_comparator_8bit_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic       in_valid;
    logic       g;
    logic       l;
    logic       eq;
    logic       out_valid;

    logic [7:0] cA;
    logic [7:0] cB;
    logic       cValid;
    logic       cG;
    logic       cL;
    logic       cEq;
    logic       cOutValid;

    int checks;
    int errors;

    parallel_comparator_8bit_core #(.OUT_REG(1)) dutReg (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .g         (g),
        .l         (l),
        .eq        (eq),
        .out_valid (out_valid)
    );

    parallel_comparator_8bit_core #(.OUT_REG(0)) dutComb (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (cA),
        .B         (cB),
        .in_valid  (cValid),
        .g         (cG),
        .l         (cL),
        .eq        (cEq),
        .out_valid (cOutValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: compare operands as plain integers, returns {g, l, eq}.
    function automatic logic [2:0] refCompare(input logic [7:0] a, input logic [7:0] b);
        int av;
        int bv;
        av = int'(a);
        bv = int'(b);
`ifdef PARALLEL_COMPARATOR_8BIT_SIGNED_EN
        if (a[7]) av = av - 256;
        if (b[7]) bv = bv - 256;
`endif
        return {av > bv, av < bv, av == bv};
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 8'd200;
        B        = 8'd3;
        #2;
        checks++;
        if ({g, l, eq, out_valid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_async got %b expected 0000", {g, l, eq, out_valid});
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({g, l, eq, out_valid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_release_idle got %b expected 0000", {g, l, eq, out_valid});
        end
    endtask

    task automatic test_directed();
        logic [7:0] da [7];
        logic [7:0] db [7];
        logic [2:0] exp;
        da = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd144, 8'd88, 8'd0};
        db = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd88, 8'd88, 8'd1};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            A        = da[i];
            B        = db[i];
            in_valid = 1'b1;
            exp      = refCompare(da[i], db[i]);
            @(posedge clk);
            #1;
            checks++;
            if ({g, l, eq, out_valid} !== {exp, 1'b1}) begin
                errors++;
                $display("[TB] FAIL directed_%0d A=%0d B=%0d got %b expected %b",
                         i, da[i], db[i], {g, l, eq, out_valid}, {exp, 1'b1});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa [4];
        logic [7:0] qb [4];
        logic [2:0] exp;
        for (int i = 0; i < 4; i++) begin
            qa[i] = 8'($urandom);
            qb[i] = 8'($urandom);
        end
        qb[2] = qa[2];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = refCompare(qa[i-1], qb[i-1]);
                checks++;
                if ({g, l, eq, out_valid} !== {exp, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL b2b_%0d got %b expected %b", i - 1, {g, l, eq, out_valid}, {exp, 1'b1});
                end
            end
            if (i < 4) begin
                A        = qa[i];
                B        = qb[i];
                in_valid = 1'b1;
            end else begin
                A        = ~qa[3];
                B        = qb[3];
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        exp = refCompare(qa[3], qb[3]);
        checks++;
        if ({g, l, eq, out_valid} !== {exp, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_hold got %b expected %b", {g, l, eq, out_valid}, {exp, 1'b0});
        end
    endtask

    task automatic test_reset_pending();
        @(negedge clk);
        A        = 8'd10;
        B        = 8'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        A = 8'd30;
        B = 8'd20;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({g, l, eq, out_valid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_midrun got %b expected 0000", {g, l, eq, out_valid});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({g, l, eq, out_valid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_pending_dropped got %b expected 0000", {g, l, eq, out_valid});
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_capture got %b expected 0", out_valid);
        end
    endtask

    task automatic test_random_stream();
        logic [2:0] held;
        logic       expValid;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rv;
        held     = 3'b000;
        expValid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            A        = ra;
            B        = rb;
            in_valid = rv;
            if (rv) held = refCompare(ra, rb);
            expValid = rv;
            @(posedge clk);
            #1;
            checks++;
            if ({g, l, eq, out_valid} !== {held, expValid} || (g & l)) begin
                errors++;
                $display("[TB] FAIL random_%0d A=%0d B=%0d v=%b got %b expected %b",
                         i, ra, rb, rv, {g, l, eq, out_valid}, {held, expValid});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_comb_sweep();
        logic [2:0] exp;
        logic       v;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                v      = 1'($urandom);
                cA     = 8'(a);
                cB     = 8'(b);
                cValid = v;
                exp    = refCompare(8'(a), 8'(b));
                #1;
                checks++;
                if ({cG, cL, cEq, cOutValid} !== {exp, v} || (cG & cL)) begin
                    errors++;
                    $display("[TB] FAIL comb_sweep A=%0d B=%0d got %b expected %b",
                             a, b, {cG, cL, cEq, cOutValid}, {exp, v});
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cA       = 8'd0;
        cB       = 8'd0;
        cValid   = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_pending();
        test_random_stream();
        test_comb_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
